scale_table_loader: RTL
=======================

SCALE_TABLE_LOADER -- requirements
Module: scale_table_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of per-channel scale entries.
REQ-002 SHALL have parameter AW, default 6, address width (log2 DEPTH).
REQ-003 SHALL have parameter DW, default 8, scale byte width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_start  input  1  single-cycle request to begin a table load.
REQ-007 SHALL have port s_valid  input  1  upstream (SoC) byte valid.
REQ-008 SHALL have port s_data  input  DW  upstream scale/checksum byte.
REQ-009 SHALL have port s_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port load_busy  output  1  high while in LOAD or CSUM.
REQ-011 SHALL have port load_done  output  1  one-cycle pulse at load completion.
REQ-012 SHALL have port csum_err  output  1  level; last load failed its checksum.
REQ-013 SHALL have port table_valid  output  1  level; table holds a verified load.
REQ-014 SHALL have port rd_addr  input  AW  CNN-engine read address.
REQ-015 SHALL have port rd_data  output  DW  registered read data.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CSUM.
REQ-017 IDLE -> LOAD on load_start; same edge clears table_valid, csum_err, index counter, running sum.
REQ-018 Byte transfer SHALL occur only on s_valid && s_ready; s_ready = 1 exactly in LOAD and CSUM, 0 in IDLE.
REQ-019 In LOAD each transfer SHALL write s_data to mem[idx], add it to an 8-bit wrapping sum, increment idx.
REQ-020 Transfer at idx == DEPTH-1 SHALL move LOAD -> CSUM; idx SHALL not wrap to 0 within a load.
REQ-021 In CSUM one transfer SHALL be accepted; pass iff (sum + s_data) mod 256 == 0.
REQ-022 On the CSUM transfer, next cycle: state IDLE, load_done = 1 for one cycle, table_valid = pass, csum_err = !pass.
REQ-023 load_start while in LOAD or CSUM SHALL be ignored.
REQ-024 s_valid low SHALL stall without state change; no timeout.
REQ-025 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented when table_valid = 1, else 8'h00.
REQ-026 Load completion and read in same cycle: read SHALL use pre-edge table_valid (returns 8'h00).
REQ-027 A failed load SHALL leave table_valid = 0 until a later passing load.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, idx 0, sum 0, s_ready 0, load_busy 0, load_done 0, csum_err 0, table_valid 0, rd_data 8'h00.
REQ-029 Memory array SHALL not be reset; table_valid gating covers stale contents.
REQ-030 rst asserted mid-load SHALL abort; a fresh load_start is required after release.

Structure
REQ-031 DEPTH, AW, DW and the FSM state encoding SHALL live in the shared CNN-engine package.
REQ-032 Storage SHALL be a sub-module scale_ram_1w1r (one write port, one registered read port).

Verification
REQ-033 Reset, load_start, bytes 0x40+i (i=0..63), checksum 0x20 -> load_done pulse, table_valid=1, csum_err=0; rd_addr 5 -> rd_data 0x45 next cycle.
REQ-034 Same stream, checksum 0x21 -> load_done pulse, csum_err=1, table_valid=0, any rd_addr -> 0x00.
REQ-035 Random s_valid gaps (~50% duty) during a passing load -> identical memory contents and exactly 65 transfers.
REQ-036 load_start pulsed at byte 30 of a load -> ignored, load completes normally at 65th transfer.
REQ-037 rst asserted at byte 40 -> all outputs at reset values immediately; new load of all 0x00 with checksum 0x00 -> table_valid=1.
REQ-038 s_valid held high in IDLE with no load_start -> s_ready stays 0, no memory writes.

Source files
------------

// File: rtl/scale_table_loader_pkg.sv
// Shared CNN-engine definitions for the per-channel scale table.
// Holds the default table geometry and the loader FSM state encoding.
package scale_table_loader_pkg;

    localparam int unsigned TABLE_DEPTH = 64;  // per-channel scale entries
    localparam int unsigned TABLE_AW    = 6;   // log2(TABLE_DEPTH)
    localparam int unsigned TABLE_DW    = 8;   // scale byte width

    // Loader FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2
    } load_state_t;

endpackage : scale_table_loader_pkg

// File: rtl/scale_ram_1w1r.sv
// Scale storage: one synchronous write port, one registered read port.
// Ports:
//   clk, rst            - clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr       - read request; rd_data = mem[rd_addr] when rd_en, else 0
//   rd_data             - registered read data
// The array itself is not reset; callers gate reads with rd_en.
module scale_ram_1w1r #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; disabled reads return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule : scale_ram_1w1r

// File: rtl/scale_table_loader.sv
// Loads a DEPTH-entry scale table from an upstream byte stream followed by a
// single checksum byte; the table is exposed to the CNN engine only after the
// 8-bit wrapping sum of all bytes (data + checksum) comes out to zero.
// Ports:
//   clk, rst        - clock, async active-high reset
//   load_start      - pulse to start a load (ignored while a load is running)
//   s_valid/s_data  - upstream byte stream; s_ready high in LOAD and CSUM
//   load_busy       - load in progress
//   load_done       - one-cycle pulse when the checksum byte is taken
//   csum_err        - last load failed its checksum
//   table_valid     - table holds a verified load
//   rd_addr/rd_data - engine read port, one-cycle latency, zero when invalid
module scale_table_loader
    import scale_table_loader_pkg::*;
#(
    parameter int unsigned DEPTH = TABLE_DEPTH,
    parameter int unsigned AW    = TABLE_AW,
    parameter int unsigned DW    = TABLE_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          load_busy,
    output logic          load_done,
    output logic          csum_err,
    output logic          table_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    load_state_t   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          table_valid_d;
    logic          csum_err_d;
    logic          load_done_d;
    logic          active_d;
    logic          wr_en;
    logic          xfer;
    logic [DW-1:0] final_sum;

    // s_ready mirrors the registered state, so it is safe to use for handshake
    assign xfer      = s_valid && s_ready;
    assign final_sum = DW'(sum_q + s_data);

    // Next-state and datapath control
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        table_valid_d = table_valid;
        csum_err_d    = csum_err;
        load_done_d   = 1'b0;
        wr_en         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d       = ST_LOAD;
                    idx_d         = '0;
                    sum_d         = '0;
                    table_valid_d = 1'b0;
                    csum_err_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    sum_d = DW'(sum_q + s_data);
                    // Index parks on the last entry rather than wrapping
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = AW'(idx_q + AW'(1));
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d       = ST_IDLE;
                    load_done_d   = 1'b1;
                    table_valid_d = (final_sum == '0);
                    csum_err_d    = (final_sum != '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            s_ready     <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            csum_err    <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            s_ready     <= active_d;
            load_busy   <= active_d;
            load_done   <= load_done_d;
            csum_err    <= csum_err_d;
            table_valid <= table_valid_d;
        end
    end

    // Reads are gated by the pre-edge table_valid, so a read coinciding with
    // load completion still returns zero
    scale_ram_1w1r #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_data (s_data),
        .rd_en   (table_valid),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule : scale_table_loader
